mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_pkg.sv | 10 +
 rtl/mult_div_if.sv | 8 +
 rtl/mult_div_unit.sv | 89 ++++++++
 tb/tb_mult_div_unit.sv | 127 ++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared state encoding, op codes and iteration count for the multiply/divide unit
package mult_div_pkg;
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV = 1'b1;
  localparam int ITERATIONS = 32;
  function automatic logic [31:0] mag(input logic [31:0] x);
    return x[31] ? -x : x;
  endfunction
endpackage

// File: rtl/mult_div_if.sv
// mult_div_if: request/result bundle between the CPU control path and the multiply/divide unit
interface mult_div_if;
  logic start, op;
  logic [31:0] a, b, hi, lo;
  logic busy, done, div_zero;
  modport master(output start, op, a, b, input hi, lo, busy, done, div_zero);
  modport slave(input start, op, a, b, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed Booth multiply / restoring divide sharing one 65-bit working register
module mult_div_unit
  import mult_div_pkg::*;
(
  input logic clock,
  input logic reset,
  mult_div_if.slave bus
);
  state_t state;
  logic [5:0] cnt;
  logic [64:0] w, w_mul, w_div;
  logic [31:0] m;
  logic qneg, rneg;
  logic [32:0] booth, rem_sh, diff;
  // Booth add is done at 33 bits so the shift keeps the true sign when m is the most negative value
  always_comb begin
    booth = w[1:0] == 2'b01 ? {w[64], w[64:33]} + {m[31], m}
          : w[1:0] == 2'b10 ? {w[64], w[64:33]} - {m[31], m}
          : {w[64], w[64:33]};
    w_mul = {booth, w[32:1]};
    rem_sh = w[63:31];
    diff = rem_sh - {1'b0, m};
    w_div = {diff[32] ? rem_sh : diff, w[30:0], ~diff[32]};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      w <= '0;
      m <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.div_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.div_zero <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          bus.busy <= 1'b1;
          cnt <= 6'(ITERATIONS);
          if (bus.op == OP_MULT) begin
            w <= {32'd0, bus.b, 1'b0};
            m <= bus.a;
            state <= MULT;
          end else if (bus.b == '0) begin
            bus.done <= 1'b1;
            bus.div_zero <= 1'b1;
            state <= DONE;
          end else begin
            w <= {33'd0, mag(bus.a)};
            m <= mag(bus.b);
            qneg <= bus.a[31] ^ bus.b[31];
            rneg <= bus.a[31];
            state <= DIV;
          end
        end
        MULT: begin
          w <= w_mul;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            bus.hi <= w_mul[64:33];
            bus.lo <= w_mul[32:1];
            bus.done <= 1'b1;
            state <= DONE;
          end
        end
        DIV: begin
          w <= w_div;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            bus.hi <= rneg ? -w_div[63:32] : w_div[63:32];
            bus.lo <= qneg ? -w_div[31:0] : w_div[31:0];
            bus.done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed checks of multiply, divide, divide-by-zero, busy-start and reset abort
module tb_mult_div_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int n;
  int pulses;
  mult_div_if bus();
  mult_div_unit dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    step();
    bus.start = 1'b0;
    bus.a = 32'hdeadbeef;
    bus.b = 32'h0badf00d;
  endtask
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 100) begin
      step();
      cycles++;
    end
  endtask
  initial begin
    bus.start = 1'b1;
    bus.op = 1'b0;
    bus.a = 32'd1;
    bus.b = 32'd1;
    step();
    step();
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_dz", 64'(bus.div_zero), 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    bus.start = 1'b0;
    reset = 1'b0;
    step();
    check("idle_busy", 64'(bus.busy), 64'd0);
    issue(1'b0, 32'd7, 32'hfffffffd);
    check("mul1_busy", 64'(bus.busy), 64'd1);
    wait_done(n);
    check("mul1_latency", 64'(n), 64'd32);
    check("mul1_result", {bus.hi, bus.lo}, 64'hffffffff_ffffffeb);
    check("mul1_dz", 64'(bus.div_zero), 64'd0);
    check("mul1_busy_done", 64'(bus.busy), 64'd1);
    step();
    check("mul1_idle_busy", 64'(bus.busy), 64'd0);
    check("mul1_single_done", 64'(bus.done), 64'd0);
    check("mul1_hold", {bus.hi, bus.lo}, 64'hffffffff_ffffffeb);
    issue(1'b0, 32'h80000000, 32'h80000000);
    wait_done(n);
    check("mul2_result", {bus.hi, bus.lo}, 64'h40000000_00000000);
    step();
    issue(1'b1, 32'hfffffff9, 32'd2);
    wait_done(n);
    check("div1_latency", 64'(n), 64'd32);
    check("div1_result", {bus.hi, bus.lo}, 64'hffffffff_fffffffd);
    step();
    issue(1'b1, 32'h80000000, 32'hffffffff);
    wait_done(n);
    check("div_ovf_result", {bus.hi, bus.lo}, 64'h00000000_80000000);
    check("div_ovf_dz", 64'(bus.div_zero), 64'd0);
    step();
    issue(1'b1, 32'h451, 32'h20);
    wait_done(n);
    check("div2_result", {bus.hi, bus.lo}, 64'h00000011_00000022);
    step();
    issue(1'b1, 32'd1234, 32'd0);
    check("dz_done", 64'(bus.done), 64'd1);
    check("dz_flag", 64'(bus.div_zero), 64'd1);
    check("dz_hold", {bus.hi, bus.lo}, 64'h00000011_00000022);
    step();
    check("dz_idle_busy", 64'(bus.busy), 64'd0);
    check("dz_flag_clear", 64'(bus.div_zero), 64'd0);
    issue(1'b0, 32'd5, 32'd6);
    repeat (9) step();
    bus.start = 1'b1;
    bus.op = 1'b1;
    bus.b = 32'd0;
    step();
    bus.start = 1'b0;
    check("busy_start_ignored", 64'(bus.done), 64'd0);
    wait_done(n);
    check("busy_start_latency", 64'(n), 64'd22);
    check("busy_start_result", {bus.hi, bus.lo}, 64'd30);
    step();
    check("busy_start_one_done", 64'(bus.done), 64'd0);
    check("b2b_idle", 64'(bus.busy), 64'd0);
    issue(1'b0, 32'd3, 32'd4);
    check("b2b_accept", 64'(bus.busy), 64'd1);
    wait_done(n);
    check("b2b_latency", 64'(n), 64'd32);
    check("b2b_result", {bus.hi, bus.lo}, 64'd12);
    step();
    issue(1'b1, 32'd100, 32'd7);
    repeat (14) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    pulses = 0;
    repeat (40) begin
      if (bus.done === 1'b1) pulses++;
      step();
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
